// File: rtl/bus_arbiter_pkg.sv
// Shared types, defaults and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM: IDLE (bus free) and GRANT (one owner drives the bus)
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_W = 16;
  // Helper width limits: NUM_REQ is bounded to 2..16
  localparam int MAX_REQ    = 16;
  localparam int MAX_IDX_W  = 4;

  // Index -> one-hot at the widest supported requester count; callers truncate
  function automatic logic [MAX_REQ-1:0] onehot_from_idx(input logic [MAX_IDX_W-1:0] idx);
    onehot_from_idx = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/bus bundle between the arbiter (master) and the agents/consumer (slave).
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*DATA_W-1:0]  req_data_i;
  logic                       bus_ready_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [DATA_W-1:0]          bus_data_o;
  logic                       bus_valid_o;
  logic [$clog2(NUM_REQ)-1:0] owner_o;
  logic                       busy_o;

  modport master (
    input  req_i, req_data_i, bus_ready_i,
    output gnt_o, bus_data_o, bus_valid_o, owner_o, busy_o
  );

  modport slave (
    output req_i, req_data_i, bus_ready_i,
    input  gnt_o, bus_data_o, bus_valid_o, owner_o, busy_o
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr_i.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IW-1:0]  off_s;
  logic [IW:0]    sum_s;

  // Rotate the request vector so ptr_i lands at bit 0
  assign dbl_s = {req_i, req_i};
  assign rot_s = N'(dbl_s >> ptr_i);

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win
  always_comb begin
    found_o = 1'b0;
    off_s   = {IW{1'b0}};
    for (int j = N - 1; j >= 0; j--) begin
      off_s   = rot_s[j] ? IW'(j) : off_s;
      found_o = found_o | rot_s[j];
    end
  end

  // Undo the rotation modulo N (N need not be a power of two)
  assign sum_s = {1'b0, ptr_i} + {1'b0, off_s};
  assign idx_o = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : sum_s[IW-1:0];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter: grants one requester at a time, forwards its beats,
// and bounds each tenure to MAX_BURST accepted beats.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.master  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

  logic               pick_found_s;
  logic [IW-1:0]      pick_idx_s;
  logic [IW:0]        ptr_inc_s;
  logic [IW-1:0]      ptr_next_s;
  logic               in_grant_s;
  logic               owner_req_s;
  logic               accept_s;
  logic [DATA_W-1:0]  data_mux_s;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Search start for the next arbitration: one past the winner, modulo NUM_REQ
  always_comb begin
    ptr_inc_s = {1'b0, pick_idx_s} + {{IW{1'b0}}, 1'b1};
    if (ptr_inc_s == (IW+1)'(NUM_REQ)) begin
      ptr_next_s = {IW{1'b0}};
    end else begin
      ptr_next_s = ptr_inc_s[IW-1:0];
    end
  end

  // gnt_q is one-hot on the owner during GRANT, so masking gives the owner's request
  assign in_grant_s  = (state_q == GRANT);
  assign owner_req_s = |(bus.req_i & gnt_q);
  assign accept_s    = in_grant_s && owner_req_s && bus.bus_ready_i;

  // Select the owner's data slice; non-owners never reach the bus
  always_comb begin
    data_mux_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      data_mux_s = (owner_q == IW'(k)) ? bus.req_data_i[k*DATA_W +: DATA_W] : data_mux_s;
    end
  end

  // FSM next state: arbitrate in IDLE, count beats and release in GRANT
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d    = GRANT;
          owner_d    = pick_idx_s;
          ptr_d      = ptr_next_s;
          gnt_d      = NUM_REQ'(onehot_from_idx(MAX_IDX_W'(pick_idx_s)));
          beat_cnt_d = {CW{1'b0}};
        end else begin
          gnt_d      = {NUM_REQ{1'b0}};
        end
      end
      GRANT: begin
        // Release on owner drop, or when the final beat of the burst is accepted
        if (!owner_req_s || (accept_s && (beat_cnt_q == CW'(MAX_BURST - 1)))) begin
          state_d    = IDLE;
          gnt_d      = {NUM_REQ{1'b0}};
          beat_cnt_d = {CW{1'b0}};
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = {NUM_REQ{1'b0}};
        beat_cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // State registers with asynchronous reset to the idle, search-from-0 state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= {IW{1'b0}};
      owner_q    <= {IW{1'b0}};
      gnt_q      <= {NUM_REQ{1'b0}};
      beat_cnt_q <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = in_grant_s;
  assign bus.bus_valid_o = in_grant_s && owner_req_s;
  assign bus.bus_data_o  = in_grant_s ? data_mux_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected {owner,data} beats,
// monitors pop and compare on every accepted beat; direct checks cover grant timing.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bif ();
  bus_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bif2 ();

  bus_arbiter #(.NUM_REQ(4), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk (clk), .rst (rst), .bus (bif)
  );
  bus_arbiter #(.NUM_REQ(4), .DATA_W(16), .MAX_BURST(1)) dut_b1 (
    .clk (clk), .rst (rst), .bus (bif2)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [17:0] exp_q  [$];
  logic [17:0] exp2_q [$];
  logic [15:0] d  [4];
  logic [15:0] d2 [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    bif.req_data_i  = {d[3], d[2], d[1], d[0]};
    bif2.req_data_i = {d2[3], d2[2], d2[1], d2[0]};
  endtask

  // Monitor for the MAX_BURST=8 arbiter
  always @(negedge clk) begin
    if (!rst && bif.bus_valid_o && bif.bus_ready_i) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", {14'd0, bif.owner_o, bif.bus_data_o}, 32'hFFFF_FFFF);
      end else begin
        check("beat", {14'd0, bif.owner_o, bif.bus_data_o}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  // Monitor for the MAX_BURST=1 arbiter
  always @(negedge clk) begin
    if (!rst && bif2.bus_valid_o && bif2.bus_ready_i) begin
      if (exp2_q.size() == 0) begin
        check("b1_beat_unexpected", {14'd0, bif2.owner_o, bif2.bus_data_o}, 32'hFFFF_FFFF);
      end else begin
        check("b1_beat", {14'd0, bif2.owner_o, bif2.bus_data_o}, {14'd0, exp2_q.pop_front()});
      end
    end
  end

  initial begin
    logic [3:0] bp_pat;
    logic [3:0] rr_oh;
    int acc;
    int cyc;
    bp_pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      d[k]  = 16'h0000;
      d2[k] = 16'h0000;
    end
    drive_data();
    bif.req_i = 4'b0000;  bif.bus_ready_i = 1'b1;
    bif2.req_i = 4'b0000; bif2.bus_ready_i = 1'b1;

    // Reset values
    tick(); tick();
    check("rst_gnt",   {28'd0, bif.gnt_o},   32'h0);
    check("rst_valid", {31'd0, bif.bus_valid_o}, 32'h0);
    check("rst_data",  {16'd0, bif.bus_data_o},  32'h0);
    check("rst_owner", {30'd0, bif.owner_o}, 32'h0);
    check("rst_busy",  {31'd0, bif.busy_o},  32'h0);
    rst = 1'b0;
    tick();

    // Round robin: all request, 5 tenures of 8 beats plus a bubble
    for (int k = 0; k < 4; k++) d[k] = 16'hC000 + 16'(k);
    drive_data();
    for (int t = 0; t < 5; t++)
      for (int b = 0; b < 8; b++) exp_q.push_back({2'(t % 4), 16'hC000 + 16'(t % 4)});
    bif.req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      rr_oh = 4'b0001 << (t % 4);
      for (int b = 0; b < 8; b++) begin
        tick();
        check("rr_gnt",   {28'd0, bif.gnt_o},       {28'd0, rr_oh});
        check("rr_valid", {31'd0, bif.bus_valid_o}, 32'h1);
      end
      tick();
      check("rr_bubble_gnt",   {28'd0, bif.gnt_o},       32'h0);
      check("rr_bubble_valid", {31'd0, bif.bus_valid_o}, 32'h0);
    end
    bif.req_i = 4'b0000;
    tick();

    // Early release: requester 1 sends 3 beats then drops
    for (int b = 0; b < 3; b++) exp_q.push_back({2'd1, 16'hA001 + 16'(b)});
    d[1] = 16'hA001; drive_data();
    bif.req_i = 4'b0010;
    tick();
    for (int b = 0; b < 3; b++) begin
      d[1] = 16'hA001 + 16'(b); drive_data();
      check("er_gnt", {28'd0, bif.gnt_o}, 32'h2);
      tick();
    end
    bif.req_i = 4'b0000;
    #1;
    check("er_drop_valid", {31'd0, bif.bus_valid_o}, 32'h0);
    tick();
    check("er_release_gnt",  {28'd0, bif.gnt_o},  32'h0);
    check("er_release_busy", {31'd0, bif.busy_o}, 32'h0);

    // Backpressure: requester 3, ready pattern 1,0,0,1
    bif.req_i = 4'b1000;
    tick();
    acc = 0; cyc = 0;
    while (acc < 8 && cyc < 40) begin
      bif.bus_ready_i = bp_pat[cyc % 4];
      d[3] = 16'hB000 + 16'(acc); drive_data();
      check("bp_gnt", {28'd0, bif.gnt_o}, 32'h8);
      if (bp_pat[cyc % 4]) begin
        exp_q.push_back({2'd3, 16'hB000 + 16'(acc)});
        acc++;
      end
      tick();
      cyc++;
    end
    check("bp_cycles", 32'(cyc), 32'd16);
    check("bp_release_gnt", {28'd0, bif.gnt_o}, 32'h0);
    bif.req_i = 4'b0000; bif.bus_ready_i = 1'b1;
    tick();

    // Isolation: requester 0 owns, requester 2 waits with 0xDEAD
    d[0] = 16'h1234; d[2] = 16'hDEAD; drive_data();
    for (int b = 0; b < 8; b++) exp_q.push_back({2'd0, 16'h1234});
    for (int b = 0; b < 8; b++) exp_q.push_back({2'd2, 16'hDEAD});
    bif.req_i = 4'b0001;
    tick();
    bif.req_i = 4'b0101;
    for (int b = 0; b < 8; b++) begin
      #1;
      check("iso_gnt0", {28'd0, bif.gnt_o},      32'h1);
      check("iso_data", {16'd0, bif.bus_data_o}, 32'h1234);
      tick();
    end
    check("iso_bubble", {28'd0, bif.gnt_o}, 32'h0);
    tick();
    for (int b = 0; b < 8; b++) begin
      check("iso_gnt2", {28'd0, bif.gnt_o}, 32'h4);
      tick();
    end
    bif.req_i = 4'b0000;
    tick();

    // Asynchronous reset mid-tenure: owner 2 after 3 accepted beats
    for (int b = 0; b < 3; b++) exp_q.push_back({2'd2, 16'hDEAD});
    bif.req_i = 4'b0100;
    tick();
    check("mid_owner", {30'd0, bif.owner_o}, 32'h2);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt",   {28'd0, bif.gnt_o},       32'h0);
    check("mid_rst_valid", {31'd0, bif.bus_valid_o}, 32'h0);
    check("mid_rst_busy",  {31'd0, bif.busy_o},      32'h0);
    check("mid_rst_data",  {16'd0, bif.bus_data_o},  32'h0);
    tick();
    rst = 1'b0;
    bif.req_i = 4'b1111;
    tick();
    check("post_rst_gnt", {28'd0, bif.gnt_o}, 32'h1);
    bif.req_i = 4'b0000;
    tick(); tick();

    // MAX_BURST=1: requester 2 held, valid/idle alternate
    d2[2] = 16'h5A5A; drive_data();
    for (int b = 0; b < 4; b++) exp2_q.push_back({2'd2, 16'h5A5A});
    bif2.req_i = 4'b0100;
    tick();
    for (int b = 0; b < 4; b++) begin
      check("b1_valid", {31'd0, bif2.bus_valid_o}, 32'h1);
      check("b1_gnt",   {28'd0, bif2.gnt_o},       32'h4);
      check("b1_owner", {30'd0, bif2.owner_o},     32'h2);
      tick();
      check("b1_idle_valid", {31'd0, bif2.bus_valid_o}, 32'h0);
      check("b1_idle_gnt",   {28'd0, bif2.gnt_o},       32'h0);
      check("b1_idle_owner", {30'd0, bif2.owner_o},     32'h2);
      tick();
    end
    bif2.req_i = 4'b0000;
    tick(); tick();

    check("sb_empty",    32'(exp_q.size()),  32'd0);
    check("b1_sb_empty", 32'(exp2_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
